// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. The serializer pops the head word in IDLE
// and sends start, DBIT data bits LSB first, and stop, each bit 16 baud ticks long.
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int ADDR_W  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_uart,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW    = $clog2(((SB_TICK > 16) ? SB_TICK : 16) + 1);
    localparam int NW    = $clog2(DBIT + 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr, r_rptr;
    logic [ADDR_W:0]   r_count, w_count_next;
    logic              r_full, r_empty;
    logic              w_push, w_pop;

    state_t            r_state, w_state_next;
    logic [CW-1:0]     r_cnt, w_cnt_next;
    logic [SW-1:0]     r_s, w_s_next;
    logic [NW-1:0]     r_n, w_n_next;
    logic [7:0]        r_b, w_b_next;
    logic              r_tx, w_tx_next;
    logic              w_tick;

    // A push is refused whenever the FIFO is full, even if a pop happens on the same clock.
    assign w_push = wr_uart && !r_full;

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + ONE;
            2'b01:   w_count_next = r_count - ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign w_tick = (r_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_pop        = 1'b0;
        w_cnt_next   = w_tick ? '0 : r_cnt + CW'(1);
        case (r_state)
            IDLE: begin
                // Holding the baud counter at zero makes every frame start on a full bit.
                w_cnt_next = '0;
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_b_next     = r_mem[r_rptr];
                    w_s_next     = '0;
                    w_n_next     = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == NW'(DBIT - 1))
                            w_state_next = STOP;
                        else
                            w_n_next = r_n + NW'(1);
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        // The line value is computed from the next state so tx and state change together.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx       = r_tx;
    assign tx_busy  = (r_state != IDLE);
    assign tx_full  = r_full;
    assign tx_empty = r_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: DVSR=2 instance for frame behaviour, default instance for bit period.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_uart = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_full, tx_empty, tx_busy, tx;
    logic       wr_d = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       full_d, empty_d, busy_d, tx_d;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .DVSR(2), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .tx(tx)
    );

    uart_tx_fifo dut_d (
        .clk(clk), .reset(reset), .wr_uart(wr_d), .w_data(data_d),
        .tx_full(full_d), .tx_empty(empty_d), .tx_busy(busy_d), .tx(tx_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples one 320-clock frame starting at frame sample 'skip'; returns decoded byte and
    // a count of framing/timing anomalies. Leaves the bench on the clock after the frame.
    task automatic capture_frame(input int skip, output logic [7:0] data, output int errs);
        logic ref_v;
        int   slot;
        errs  = 0;
        data  = 8'h00;
        ref_v = 1'b1;
        for (int k = skip; k < 320; k++) begin
            slot = k / 32;
            if (k == skip || (k % 32) == 0) ref_v = tx;
            else if (tx !== ref_v) errs++;
            if (tx_busy !== 1'b1) errs++;
            if (slot == 0 && tx !== 1'b0) errs++;
            if (slot == 9 && tx !== 1'b1) errs++;
            if (slot >= 1 && slot <= 8 && (k % 32) == 16) data[slot-1] = tx;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_uart = 1'b1; w_data = 8'h77;
        tick(); tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", tx_full); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", tx_empty); end
        reset = 1'b1; wr_uart = 1'b0;
        tick(); tick();
        checks++; if (tx_empty !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ignored got empty=%b busy=%b want 1 0", tx_empty, tx_busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        int         e;
        wr_uart = 1'b1; w_data = 8'h05;
        tick();
        wr_uart = 1'b0; w_data = 8'hFF;
        checks++; if (tx !== 1'b1 || tx_empty !== 1'b0) begin
            errors++; $display("FAIL single_lat1 got tx=%b empty=%b want 1 0", tx, tx_empty);
        end
        tick();
        checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL single_lat2 got tx=%b busy=%b want 0 1", tx, tx_busy);
        end
        capture_frame(0, d, e);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL single_data got %h want 05", d); end
        checks++; if (e !== 0) begin errors++; $display("FAIL single_timing got %0d anomalies want 0", e); end
        checks++; if (tx_busy !== 1'b0 || tx !== 1'b1 || tx_empty !== 1'b1) begin
            errors++; $display("FAIL single_end got busy=%b tx=%b empty=%b want 0 1 1", tx_busy, tx, tx_empty);
        end
        repeat (5) tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int         e;
        wr_uart = 1'b1; w_data = 8'h01;
        tick();
        w_data = 8'h04;
        tick();
        w_data = 8'h80;
        tick();
        wr_uart = 1'b0;
        capture_frame(1, d, e);
        checks++; if (d !== 8'h01 || e !== 0) begin errors++; $display("FAIL b2b_f1 got %h/%0d want 01/0", d, e); end
        checks++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL b2b_gap1 got busy=%b tx=%b want 0 1", tx_busy, tx);
        end
        tick();
        checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL b2b_notempty got %b want 0", tx_empty); end
        capture_frame(0, d, e);
        checks++; if (d !== 8'h04 || e !== 0) begin errors++; $display("FAIL b2b_f2 got %h/%0d want 04/0", d, e); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap2 got busy=%b want 0", tx_busy); end
        tick();
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", tx_empty); end
        capture_frame(0, d, e);
        checks++; if (d !== 8'h80 || e !== 0) begin errors++; $display("FAIL b2b_f3 got %h/%0d want 80/0", d, e); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b want 0", tx_busy); end
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] exp_q [4];
        int         e;
        int         bad;
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        wr_uart = 1'b1; w_data = 8'h3C;
        tick();
        wr_uart = 1'b0;
        tick();
        wr_uart = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = 8'hA0 + 8'(i);
            tick();
        end
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", tx_full); end
        w_data = 8'hA4;
        tick();
        wr_uart = 1'b0;
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full_hold got %b want 1", tx_full); end
        capture_frame(5, d, e);
        checks++; if (d !== 8'h3C || e !== 0) begin errors++; $display("FAIL ovf_inflight got %h/%0d want 3C/0", d, e); end
        wr_uart = 1'b1; w_data = 8'hEE;
        checks++; if (tx_full !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL ovf_popclk got full=%b busy=%b want 1 0", tx_full, tx_busy);
        end
        tick();
        wr_uart = 1'b0;
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL ovf_full_fall got %b want 0", tx_full); end
        for (int i = 0; i < 4; i++) begin
            capture_frame(0, d, e);
            checks++; if (d !== exp_q[i] || e !== 0) begin
                errors++; $display("FAIL ovf_word%0d got %h/%0d want %h/0", i, d, e, exp_q[i]);
            end
            if (i < 3) tick();
        end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", tx_empty); end
        bad = 0;
        repeat (40) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_dropped got %0d busy clocks want 0", bad); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        wr_uart = 1'b1; w_data = 8'hFF;
        tick();
        w_data = 8'h11;
        tick();
        w_data = 8'h22;
        tick();
        wr_uart = 1'b0;
        repeat (139) tick();
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL rst_bit3 got tx=%b busy=%b want 1 1", tx, tx_busy);
        end
        reset = 1'b0; wr_uart = 1'b1; w_data = 8'h33;
        tick();
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1 || tx_full !== 1'b0) begin
            errors++; $display("FAIL rst_abort got tx=%b busy=%b empty=%b full=%b want 1 0 1 0",
                               tx, tx_busy, tx_empty, tx_full);
        end
        tick();
        reset = 1'b1; wr_uart = 1'b0;
        bad = 0;
        repeat (400) begin
            tick();
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_resume got %0d active clocks want 0", bad); end
    endtask

    task automatic test_default_baud();
        int cnt;
        wr_d = 1'b1; data_d = 8'h01;
        tick();
        wr_d = 1'b0;
        tick();
        cnt = 0;
        while (tx_d === 1'b0 && cnt < 6000) begin
            cnt++;
            tick();
        end
        checks++; if (cnt !== 2608) begin errors++; $display("FAIL dflt_start got %0d clocks want 2608", cnt); end
        cnt = 0;
        while (tx_d === 1'b1 && cnt < 6000) begin
            cnt++;
            tick();
        end
        checks++; if (cnt !== 2608) begin errors++; $display("FAIL dflt_bit0 got %0d clocks want 2608", cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_default_baud();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
